// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: LANES payload lanes with valid, stall hold/bubble, flush, in-order kill.
// Optional stall statistics (hold_cnt / bubble_cnt) are enabled by defining PIPE_STALL_CNT_EN.

module pipe_stage_lane #(
  parameter int PAYLOAD_W = 112
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 adv,
  input  logic                 live,
  input  logic [PAYLOAD_W-1:0] din,
  output logic                 vld,
  output logic [PAYLOAD_W-1:0] dout
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (adv) begin
      vld  <= live;
      dout <= live ? din : '0;
    end
  end
endmodule

module pipe_stage_reg #(
  parameter int LANES     = 1,
  parameter int PAYLOAD_W = 112,
  parameter int STALL_W   = 6,
  parameter int STAGE     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [STALL_W-1:0]           stall,
  input  logic                         flush,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES-1:0]             in_kill,
  input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES*PAYLOAD_W-1:0]   out_payload
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]             hold_cnt,
  output logic [CNT_W-1:0]             bubble_cnt
`endif
);
  generate
    if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
    end
    if (LANES < 1) begin : g_bad_lanes
      $error("pipe_stage_reg: LANES must be at least 1");
    end
    if (PAYLOAD_W < 1) begin : g_bad_width
      $error("pipe_stage_reg: PAYLOAD_W must be at least 1");
    end
  endgenerate

  logic up_stall, dn_stall, adv, bubble, hold;
  assign up_stall = stall[STAGE];
  assign dn_stall = stall[STAGE+1];
  // Upstream running always advances, even if downstream claims a stall.
  assign adv    = ~up_stall;
  assign bubble = up_stall & ~dn_stall;
  assign hold   = up_stall & dn_stall;

  // A kill on lane k squashes k and every younger lane.
  logic [LANES-1:0] kill_pfx;
  always_comb begin
    logic acc;
    acc      = 1'b0;
    kill_pfx = '0;
    for (int i = 0; i < LANES; i++) begin
      acc         = acc | in_kill[i];
      kill_pfx[i] = acc;
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      pipe_stage_lane #(.PAYLOAD_W(PAYLOAD_W)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush | bubble),
        .adv  (adv),
        .live (in_valid[g] & ~kill_pfx[g]),
        .din  (in_payload[g*PAYLOAD_W +: PAYLOAD_W]),
        .vld  (out_valid[g]),
        .dout (out_payload[g*PAYLOAD_W +: PAYLOAD_W])
      );
    end
  endgenerate

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      bubble_cnt <= '0;
    end else if (!flush) begin
      if (hold && hold_cnt != '1)     hold_cnt   <= hold_cnt + 1'b1;
      if (bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(~up_stall && dn_stall))
        else $warning("pipe_stage_reg: downstream stalled while upstream runs; treated as advance");
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with two 16-bit lanes, STAGE=3 of a 6-bit stall vector.
// Counter checks run only when PIPE_STALL_CNT_EN is defined (CNT_W=4).

module tb_pipe_stage_reg;
  localparam int L = 2, PW = 16, SW = 6, ST = 3, CW = 4;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [SW-1:0]   stall;
  logic [L-1:0]    in_valid, in_kill, out_valid;
  logic [L*PW-1:0] in_payload, out_payload;
`ifdef PIPE_STALL_CNT_EN
  logic [CW-1:0]   hold_cnt, bubble_cnt;
`endif

  int passes = 0, total = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.LANES(L), .PAYLOAD_W(PW), .STALL_W(SW), .STAGE(ST), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_kill(in_kill), .in_payload(in_payload),
    .out_valid(out_valid), .out_payload(out_payload)
`ifdef PIPE_STALL_CNT_EN
    , .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] v, input logic [31:0] p);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".payload"}, 64'(out_payload), 64'(p));
  endtask

  task automatic drive(input logic [5:0] s, input logic f, input logic [1:0] v,
                       input logic [1:0] k, input logic [31:0] p);
    stall = s; flush = f; in_valid = v; in_kill = k; in_payload = p;
  endtask

  initial begin
    rst = 1'b1;
    drive(6'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), $urandom);
    step(); chk_out("rst_c1", 2'b00, 32'h0);
    drive(6'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), $urandom);
    step(); chk_out("rst_c2", 2'b00, 32'h0);
    rst = 1'b0;

    drive(6'b000000, 0, 2'b11, 2'b00, {16'h3C3C, 16'hA5A5});
    step(); chk_out("adv_ab", 2'b11, {16'h3C3C, 16'hA5A5});
    drive(6'b000000, 0, 2'b11, 2'b01, {16'h3C3C, 16'hA5A5});
    step(); chk_out("kill_l0", 2'b00, 32'h0);
    drive(6'b000000, 0, 2'b11, 2'b10, {16'h3C3C, 16'hA5A5});
    step(); chk_out("kill_l1", 2'b01, {16'h0000, 16'hA5A5});
    drive(6'b000000, 0, 2'b10, 2'b00, {16'h1111, 16'h2222});
    step(); chk_out("inval_l0", 2'b10, {16'h1111, 16'h0000});

    drive(6'b000000, 0, 2'b11, 2'b00, {16'hDDDD, 16'hCCCC});
    step(); chk_out("adv_cd", 2'b11, {16'hDDDD, 16'hCCCC});
    drive(6'b001000, 0, 2'b11, 2'b00, {16'h7777, 16'h8888});
    step(); chk_out("bubble", 2'b00, 32'h0);

    drive(6'b000000, 0, 2'b11, 2'b00, {16'hFFF0, 16'hE00E});
    step(); chk_out("adv_ef", 2'b11, {16'hFFF0, 16'hE00E});
    drive(6'b011000, 0, 2'b01, 2'b00, {16'h1234, 16'h5678});
    for (int i = 0; i < 5; i++) begin
      step(); chk_out($sformatf("hold%0d", i), 2'b11, {16'hFFF0, 16'hE00E});
    end

    drive(6'b100111, 0, 2'b11, 2'b00, {16'h0F0F, 16'hF0F0});
    step(); chk_out("other_bits", 2'b11, {16'h0F0F, 16'hF0F0});

    drive(6'b011000, 1, 2'b11, 2'b00, {16'h4444, 16'h5555});
    step(); chk_out("flush_hold", 2'b00, 32'h0);
    drive(6'b000000, 0, 2'b11, 2'b00, {16'h6666, 16'h9999});
    step(); chk_out("post_flush", 2'b11, {16'h6666, 16'h9999});

    drive(6'b010000, 0, 2'b11, 2'b00, {16'hABCD, 16'h0123});
    step(); chk_out("illegal_adv", 2'b11, {16'hABCD, 16'h0123});

    drive(6'b011000, 0, 2'b11, 2'b00, {16'h5A5A, 16'hC3C3});
    rst = 1'b1;
    step(); chk_out("rst_in_hold", 2'b00, 32'h0);
    rst = 1'b0;
    step(); chk_out("hold_after_rst", 2'b00, 32'h0);
    drive(6'b000000, 0, 2'b01, 2'b00, {16'h5A5A, 16'hC3C3});
    step(); chk_out("adv_after_rst", 2'b01, {16'h0000, 16'hC3C3});

`ifdef PIPE_STALL_CNT_EN
    rst = 1'b1;
    step(); check("cnt_rst_h", 64'(hold_cnt), 64'd0); check("cnt_rst_b", 64'(bubble_cnt), 64'd0);
    rst = 1'b0;
    drive(6'b011000, 0, 2'b11, 2'b00, 32'h0);
    for (int i = 0; i < 20; i++) step();
    check("hold_sat", 64'(hold_cnt), 64'hF);
    drive(6'b001000, 0, 2'b11, 2'b00, 32'h0);
    for (int i = 0; i < 3; i++) step();
    check("bubble3", 64'(bubble_cnt), 64'd3);
    drive(6'b001000, 1, 2'b11, 2'b00, 32'h0);
    step(); check("bubble_flush", 64'(bubble_cnt), 64'd3);
    rst = 1'b1;
    step(); check("cnt_clr_h", 64'(hold_cnt), 64'd0); check("cnt_clr_b", 64'(bubble_cnt), 64'd0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
